// File: rtl/nes_bus_pkg.sv
// Shared definitions for the CPU bus responder: address map, OAM DMA
// trigger address and register index, DMA state encoding and the region
// decoder used both by CPU accesses and by the DMA source fetch.
package nes_bus_pkg;

    localparam logic [15:0] RamLimit   = 16'h1FFF;
    localparam logic [15:0] PpuBase    = 16'h2000;
    localparam logic [15:0] PpuLimit   = 16'h3FFF;
    localparam logic [15:0] IoBase     = 16'h4000;
    localparam logic [15:0] IoLimit    = 16'h7FFF;
    localparam logic [15:0] PrgBase    = 16'h8000;

    localparam logic [15:0] OamDmaAddr = 16'h4014;
    localparam logic [2:0]  OamDataReg = 3'd4;

    localparam int unsigned RamAddrWidth = 11;

    typedef enum logic [1:0] {
        DmaIdle,
        DmaAlign,
        DmaRd,
        DmaWr
    } dma_state_e;

    typedef enum logic [1:0] {
        RegionRam,
        RegionPpu,
        RegionIo,
        RegionPrg
    } region_e;

    function automatic region_e decode_region(input logic [15:0] addr);
        region_e r;
        r = RegionPrg;
        if (addr <= RamLimit) begin
            r = RegionRam;
        end else if (addr >= PpuBase && addr <= PpuLimit) begin
            r = RegionPpu;
        end else if (addr >= IoBase && addr <= IoLimit) begin
            r = RegionIo;
        end else if (addr >= PrgBase) begin
            r = RegionPrg;
        end
        return r;
    endfunction

endpackage

// File: rtl/cpu_bus_responder_if.sv
// Bus bundle between the CPU/system side (master) and the responder (slave).
//   addr/rw/wdata    CPU access, one per cycle
//   rdata/rdy        registered read data, stall indication
//   prg_addr/data    PRG ROM port (combinational read)
//   ppu_*            PPU register port with one-cycle strobes
//   dma_active       OAM DMA in progress
interface cpu_bus_responder_if;

    logic [15:0] addr;
    logic        rw;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        rdy;
    logic [14:0] prg_addr;
    logic [7:0]  prg_data;
    logic [2:0]  ppu_reg;
    logic        ppu_we;
    logic        ppu_re;
    logic [7:0]  ppu_wdata;
    logic [7:0]  ppu_rdata;
    logic        dma_active;

    modport master (
        output addr, rw, wdata, prg_data, ppu_rdata,
        input  rdata, rdy, prg_addr, ppu_reg, ppu_we, ppu_re, ppu_wdata, dma_active
    );

    modport slave (
        input  addr, rw, wdata, prg_data, ppu_rdata,
        output rdata, rdy, prg_addr, ppu_reg, ppu_we, ppu_re, ppu_wdata, dma_active
    );

endinterface

// File: rtl/cpu_work_ram.sv
// 2 KB CPU work RAM: single-port synchronous, read-first.
//   clk_ph1  clock
//   en       port enable
//   we       write enable (when en)
//   addr     word address
//   wdata    write data
//   rdata    registered read data; returns old contents on a write
module cpu_work_ram #(
    parameter int unsigned AddrWidth = 11
) (
    input  logic                 clk_ph1,
    input  logic                 en,
    input  logic                 we,
    input  logic [AddrWidth-1:0] addr,
    input  logic [7:0]           wdata,
    output logic [7:0]           rdata
);

    logic [7:0] mem [2**AddrWidth];

    always_ff @(posedge clk_ph1) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/cpu_bus_responder.sv
// CPU bus responder: decodes the CPU address map onto work RAM, PPU
// registers and PRG ROM, and runs the OAM DMA engine that stalls the CPU
// while copying a 256-byte page into PPU register 4.
//   clk_ph1  clock, rising edge
//   rst      synchronous active-low reset
//   bus      slave side of cpu_bus_responder_if
module cpu_bus_responder
    import nes_bus_pkg::*;
(
    input  logic                      clk_ph1,
    input  logic                      rst,
    cpu_bus_responder_if.slave        bus
);

    dma_state_e state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] index_q, index_d;
    logic       extra_q, extra_d;
    logic [7:0] byte_q, byte_d;
    logic       from_ram_q, from_ram_d;
    logic       parity_q;
    logic [7:0] rdata_q, rdata_d;
    logic       ram_pending_q, ram_pending_d;

    logic                    ram_en;
    logic                    ram_we;
    logic [RamAddrWidth-1:0] ram_addr;
    logic [7:0]              ram_wdata;
    logic [7:0]              ram_q;

    logic        ppu_we;
    logic        ppu_re;
    logic [2:0]  ppu_reg;
    logic [7:0]  ppu_wdata;
    logic [14:0] prg_addr;

    logic [15:0] dma_addr;
    region_e     cpu_region;
    region_e     dma_region;

    assign dma_addr   = {page_q, index_q};
    assign cpu_region = decode_region(bus.addr);
    assign dma_region = decode_region(dma_addr);

    cpu_work_ram #(
        .AddrWidth(RamAddrWidth)
    ) u_ram (
        .clk_ph1(clk_ph1),
        .en     (ram_en),
        .we     (ram_we),
        .addr   (ram_addr),
        .wdata  (ram_wdata),
        .rdata  (ram_q)
    );

    always_comb begin
        state_d       = state_q;
        page_d        = page_q;
        index_d       = index_q;
        extra_d       = extra_q;
        byte_d        = byte_q;
        from_ram_d    = from_ram_q;
        // A RAM read lands in ram_q one cycle late; fold it into rdata_q on
        // the following edge so rdata keeps holding once ram_q is reused.
        rdata_d       = ram_pending_q ? ram_q : rdata_q;
        ram_pending_d = 1'b0;
        ram_en        = 1'b0;
        ram_we        = 1'b0;
        ram_addr      = bus.addr[RamAddrWidth-1:0];
        ram_wdata     = bus.wdata;
        ppu_we        = 1'b0;
        ppu_re        = 1'b0;
        ppu_reg       = bus.addr[2:0];
        ppu_wdata     = bus.wdata;
        prg_addr      = bus.addr[14:0];

        case (state_q)
            DmaIdle: begin
                // Strobes are gated by rst so nothing reaches the PPU/RAM in reset.
                if (rst) begin
                    case (cpu_region)
                        RegionRam: begin
                            ram_en        = 1'b1;
                            ram_we        = ~bus.rw;
                            ram_pending_d = bus.rw;
                        end
                        RegionPpu: begin
                            if (bus.rw) begin
                                ppu_re  = 1'b1;
                                rdata_d = bus.ppu_rdata;
                            end else begin
                                ppu_we  = 1'b1;
                            end
                        end
                        RegionPrg: begin
                            if (bus.rw) begin
                                rdata_d = bus.prg_data;
                            end
                        end
                        default: begin
                            if (!bus.rw && bus.addr == OamDmaAddr) begin
                                state_d = DmaAlign;
                                page_d  = bus.wdata;
                                index_d = 8'h00;
                                extra_d = parity_q;
                            end
                        end
                    endcase
                end
            end
            DmaAlign: begin
                prg_addr = dma_addr[14:0];
                if (extra_q) begin
                    extra_d = 1'b0;
                end else begin
                    state_d = DmaRd;
                end
            end
            DmaRd: begin
                prg_addr   = dma_addr[14:0];
                ram_en     = 1'b1;
                ram_addr   = dma_addr[RamAddrWidth-1:0];
                byte_d     = (dma_region == RegionPrg) ? bus.prg_data : 8'h00;
                from_ram_d = (dma_region == RegionRam);
                state_d    = DmaWr;
            end
            DmaWr: begin
                prg_addr  = dma_addr[14:0];
                ppu_we    = rst;
                ppu_reg   = OamDataReg;
                ppu_wdata = from_ram_q ? ram_q : byte_q;
                index_d   = index_q + 8'd1;
                state_d   = (index_q == 8'hFF) ? DmaIdle : DmaRd;
            end
            default: state_d = DmaIdle;
        endcase
    end

    always_ff @(posedge clk_ph1) begin
        if (!rst) begin
            state_q       <= DmaIdle;
            page_q        <= 8'h00;
            index_q       <= 8'h00;
            extra_q       <= 1'b0;
            byte_q        <= 8'h00;
            from_ram_q    <= 1'b0;
            parity_q      <= 1'b0;
            rdata_q       <= 8'h00;
            ram_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            page_q        <= page_d;
            index_q       <= index_d;
            extra_q       <= extra_d;
            byte_q        <= byte_d;
            from_ram_q    <= from_ram_d;
            parity_q      <= ~parity_q;
            rdata_q       <= rdata_d;
            ram_pending_q <= ram_pending_d;
        end
    end

    assign bus.rdata      = ram_pending_q ? ram_q : rdata_q;
    assign bus.rdy        = (state_q == DmaIdle);
    assign bus.dma_active = (state_q != DmaIdle);
    assign bus.prg_addr   = prg_addr;
    assign bus.ppu_reg    = ppu_reg;
    assign bus.ppu_we     = ppu_we;
    assign bus.ppu_re     = ppu_re;
    assign bus.ppu_wdata  = ppu_wdata;

endmodule
